// File: rtl/bram_portb_arbiter.sv
// Round-robin arbiter sharing BRAM port B between two requesters. Port-B drive is registered and
// read data is routed back to the owning requester through an in-flight tag pipe.
module bram_portb_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  input  logic                req0_valid,
  input  logic                req0_we,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_din,
  output logic                req0_gnt,
  output logic                req0_rvalid,
  output logic [DATA_W-1:0]   req0_rdata,
  input  logic                req1_valid,
  input  logic                req1_we,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_din,
  output logic                req1_gnt,
  output logic                req1_rvalid,
  output logic [DATA_W-1:0]   req1_rdata,
  output logic                BRAM_PORTB_en,
  output logic [DATA_W/8-1:0] BRAM_PORTB_we,
  output logic [ADDR_W-1:0]   BRAM_PORTB_addr,
  output logic [DATA_W-1:0]   BRAM_PORTB_din,
  input  logic [DATA_W-1:0]   BRAM_PORTB_dout,
  output logic                busy
);

  localparam int unsigned WeW = DATA_W / 8;

  logic              last_gnt_q, last_gnt_d;
  logic              en_q, en_d;
  logic [WeW-1:0]    we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [RD_LAT:0]   tag_vld_q, tag_vld_d;
  logic [RD_LAT:0]   tag_id_q, tag_id_d;
  logic              rv0_q, rv0_d, rv1_q, rv1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;

  logic              gnt0, gnt1, accept, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;

  // last_gnt_q = 1 means requester 1 won last, so requester 0 wins the next tie.
  always_comb begin
    gnt0     = req0_valid & (~req1_valid | last_gnt_q);
    gnt1     = req1_valid & (~req0_valid | ~last_gnt_q);
    accept   = gnt0 | gnt1;
    sel_we   = gnt1 ? req1_we   : req0_we;
    sel_addr = gnt1 ? req1_addr : req0_addr;
    sel_din  = gnt1 ? req1_din  : req0_din;
  end

  always_comb begin
    last_gnt_d = accept ? gnt1 : last_gnt_q;
    en_d       = accept;
    we_d       = {WeW{accept & sel_we}};
    addr_d     = accept ? sel_addr : addr_q;
    din_d      = accept ? sel_din  : din_q;
    // Stage i of the tag pipe lines up with port-B cycle k+1+i; stage RD_LAT meets dout.
    tag_vld_d  = {tag_vld_q[RD_LAT-1:0], accept & ~sel_we};
    tag_id_d   = {tag_id_q[RD_LAT-1:0], gnt1};
    rv0_d      = tag_vld_q[RD_LAT] & ~tag_id_q[RD_LAT];
    rv1_d      = tag_vld_q[RD_LAT] &  tag_id_q[RD_LAT];
    rd0_d      = rv0_d ? BRAM_PORTB_dout : rd0_q;
    rd1_d      = rv1_d ? BRAM_PORTB_dout : rd1_q;
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      last_gnt_q <= 1'b1;
      en_q       <= 1'b0;
      we_q       <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
    end
  end

  assign req0_gnt        = gnt0;
  assign req1_gnt        = gnt1;
  assign req0_rvalid     = rv0_q;
  assign req1_rvalid     = rv1_q;
  assign req0_rdata      = rd0_q;
  assign req1_rdata      = rd1_q;
  assign BRAM_PORTB_en   = en_q;
  assign BRAM_PORTB_we   = we_q;
  assign BRAM_PORTB_addr = addr_q;
  assign BRAM_PORTB_din  = din_q;
  assign busy            = en_q | (|tag_vld_q);

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Bench for bram_portb_arbiter: RD_LAT=1 and RD_LAT=2 instances driven in lockstep, each with its
// own BRAM model, checked by a scoreboard fed from a transaction-level reference model.
module tb_bram_portb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic       v0 = 1'b0, we0 = 1'b0, v1 = 1'b0, we1 = 1'b0;
  logic [9:0] a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;

  logic [1:0] g0, g1, rv0, rv1, en, busy;
  logic [1:0][31:0] rdat0, rdat1, bdin, bdout;
  logic [1:0][3:0] bwe;
  logic [1:0][9:0] baddr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_portb_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) u_dut_l1 (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .req0_valid(v0), .req0_we(we0), .req0_addr(a0), .req0_din(d0),
    .req0_gnt(g0[0]), .req0_rvalid(rv0[0]), .req0_rdata(rdat0[0]),
    .req1_valid(v1), .req1_we(we1), .req1_addr(a1), .req1_din(d1),
    .req1_gnt(g1[0]), .req1_rvalid(rv1[0]), .req1_rdata(rdat1[0]),
    .BRAM_PORTB_en(en[0]), .BRAM_PORTB_we(bwe[0]), .BRAM_PORTB_addr(baddr[0]),
    .BRAM_PORTB_din(bdin[0]), .BRAM_PORTB_dout(bdout[0]), .busy(busy[0])
  );

  bram_portb_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(2)) u_dut_l2 (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .req0_valid(v0), .req0_we(we0), .req0_addr(a0), .req0_din(d0),
    .req0_gnt(g0[1]), .req0_rvalid(rv0[1]), .req0_rdata(rdat0[1]),
    .req1_valid(v1), .req1_we(we1), .req1_addr(a1), .req1_din(d1),
    .req1_gnt(g1[1]), .req1_rvalid(rv1[1]), .req1_rdata(rdat1[1]),
    .BRAM_PORTB_en(en[1]), .BRAM_PORTB_we(bwe[1]), .BRAM_PORTB_addr(baddr[1]),
    .BRAM_PORTB_din(bdin[1]), .BRAM_PORTB_dout(bdout[1]), .busy(busy[1])
  );

  // BRAM port-B models: instance 0 without, instance 1 with an output register.
  logic [31:0] mem [2][1024];
  logic [1:0][31:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (en[i]) begin
        if (bwe[i] != 4'h0) mem[i][baddr[i]] = bdin[i];
        else s1[i] <= mem[i][baddr[i]];
      end
      s2[i] <= s1[i];
    end
  end
  assign bdout[0] = s1[0];
  assign bdout[1] = s2[1];

  // Reference model: memory contents as seen by accepted transactions, round-robin owner.
  typedef struct { int cyc; logic [31:0] data; } rd_t;
  typedef struct { int cyc; logic we; logic [9:0] addr; logic [31:0] din; } pb_t;
  logic [31:0] ref_mem [1024];
  logic ref_last = 1'b1;
  rd_t rq [4][$];  // index = instance*2 + requester
  pb_t pq [2][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d actual=event required=none", nm, cyc);
  endtask

  task automatic accept(input int r);
    logic we;
    logic [9:0] a;
    logic [31:0] d;
    pb_t p;
    rd_t e;
    we = r ? we1 : we0;
    a  = r ? a1 : a0;
    d  = r ? d1 : d0;
    ref_last = (r == 1);
    for (int i = 0; i < 2; i++) begin
      p.cyc = cyc + 1; p.we = we; p.addr = a; p.din = d;
      pq[i].push_back(p);
      if (!we) begin
        e.cyc = cyc + 3 + i; e.data = ref_mem[a];
        rq[i*2+r].push_back(e);
      end
    end
    if (we) ref_mem[a] = d;
  endtask

  // One bus cycle: inputs already driven; check grants at mid-cycle, return to posedge+1.
  task automatic tick(output logic got0, output logic got1);
    logic e0, e1;
    @(negedge clk);
    e0 = v0 & (~v1 | ref_last);
    e1 = v1 & (~v0 | ~ref_last);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("gnt0_l%0d", i + 1), {31'b0, g0[i]}, {31'b0, e0});
      chk($sformatf("gnt1_l%0d", i + 1), {31'b0, g1[i]}, {31'b0, e1});
    end
    if (e0) accept(0);
    if (e1) accept(1);
    got0 = e0;
    got1 = e1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic x0, x1;
    v0 = 1'b0; v1 = 1'b0;
    for (int k = 0; k < n; k++) tick(x0, x1);
  endtask

  task automatic chk_zero(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_en"}, {31'b0, en[i]}, 32'h0);
      chk({nm, "_we"}, {28'b0, bwe[i]}, 32'h0);
      chk({nm, "_addr"}, {22'b0, baddr[i]}, 32'h0);
      chk({nm, "_rvalid"}, {30'b0, rv1[i], rv0[i]}, 32'h0);
      chk({nm, "_rdata0"}, rdat0[i], 32'h0);
      chk({nm, "_rdata1"}, rdat1[i], 32'h0);
      chk({nm, "_busy"}, {31'b0, busy[i]}, 32'h0);
    end
  endtask

  // Monitor: compares port-B drive and read returns against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (en[i]) begin
          if (pq[i].size() == 0) flag($sformatf("unexpected_en_l%0d", i + 1));
          else begin
            pb_t p;
            p = pq[i].pop_front();
            chk($sformatf("en_cycle_l%0d", i + 1), cyc, p.cyc);
            chk($sformatf("bram_we_l%0d", i + 1), {28'b0, bwe[i]}, {28'b0, {4{p.we}}});
            chk($sformatf("bram_addr_l%0d", i + 1), {22'b0, baddr[i]}, {22'b0, p.addr});
            if (p.we) chk($sformatf("bram_din_l%0d", i + 1), bdin[i], p.din);
          end
        end else begin
          if (bwe[i] != 4'h0) flag($sformatf("we_without_en_l%0d", i + 1));
          if (pq[i].size() != 0 && pq[i][0].cyc <= cyc) begin
            flag($sformatf("missing_en_l%0d", i + 1));
            void'(pq[i].pop_front());
          end
        end
        for (int r = 0; r < 2; r++) begin
          logic rv;
          logic [31:0] rd;
          int q;
          q  = i * 2 + r;
          rv = r ? rv1[i] : rv0[i];
          rd = r ? rdat1[i] : rdat0[i];
          if (rv) begin
            if (rq[q].size() == 0) flag($sformatf("unexpected_rvalid%0d_l%0d", r, i + 1));
            else begin
              rd_t e;
              e = rq[q].pop_front();
              chk($sformatf("rvalid%0d_cycle_l%0d", r, i + 1), cyc, e.cyc);
              chk($sformatf("rdata%0d_l%0d", r, i + 1), rd, e.data);
            end
          end else if (rq[q].size() != 0 && rq[q][0].cyc <= cyc) begin
            flag($sformatf("missing_rvalid%0d_l%0d", r, i + 1));
            void'(rq[q].pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic x0, x1;
    logic p0, p1;
    for (int k = 0; k < 1024; k++) begin
      ref_mem[k] = $urandom;
      mem[0][k]  = ref_mem[k];
      mem[1][k]  = ref_mem[k];
    end
    ref_mem[5] = 32'hDEADBEEF; mem[0][5] = 32'hDEADBEEF; mem[1][5] = 32'hDEADBEEF;

    // Reset state
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read of 0xDEADBEEF
    v0 = 1'b1; we0 = 1'b0; a0 = 10'h005;
    tick(x0, x1);
    idle(6);

    // Both read continuously for 6 cycles
    v0 = 1'b1; we0 = 1'b0; a0 = 10'h100;
    v1 = 1'b1; we1 = 1'b0; a1 = 10'h200;
    for (int k = 0; k < 6; k++) begin
      tick(x0, x1);
      if (x0) a0 = a0 + 10'd1;
      if (x1) a1 = a1 + 10'd1;
    end
    idle(6);

    // Write from req1 then read-back by req0 the next cycle
    v1 = 1'b1; we1 = 1'b1; a1 = 10'h3FF; d1 = 32'h12345678;
    tick(x0, x1);
    v1 = 1'b0;
    v0 = 1'b1; we0 = 1'b0; a0 = 10'h3FF;
    tick(x0, x1);
    idle(6);

    // Back-to-back reads 0x010..0x013
    for (int k = 0; k < 4; k++) begin
      v0 = 1'b1; we0 = 1'b0; a0 = 10'h010 + 10'(k);
      tick(x0, x1);
    end
    idle(6);

    // Randomized traffic with hold-until-grant and occasional request drops
    p0 = 1'b0; p1 = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (p0 && $urandom_range(0, 99) < 10) p0 = 1'b0;
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1'b1; we0 = ($urandom_range(0, 99) < 30); a0 = 10'($urandom_range(0, 31));
        d0 = $urandom;
      end
      if (p1 && $urandom_range(0, 99) < 10) p1 = 1'b0;
      if (!p1 && $urandom_range(0, 99) < 60) begin
        p1 = 1'b1; we1 = ($urandom_range(0, 99) < 30); a1 = 10'($urandom_range(0, 31));
        d1 = $urandom;
      end
      v0 = p0; v1 = p1;
      tick(x0, x1);
      if (x0) p0 = 1'b0;
      if (x1) p1 = 1'b0;
    end
    idle(8);

    // Reset while two reads are in flight
    v0 = 1'b1; we0 = 1'b0; a0 = 10'h020;
    tick(x0, x1);
    a0 = 10'h021;
    tick(x0, x1);
    v0 = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("async_reset");
    for (int q = 0; q < 4; q++) rq[q].delete();
    for (int i = 0; i < 2; i++) pq[i].delete();
    ref_last = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);
    v0 = 1'b1; we0 = 1'b0; a0 = 10'h005;
    v1 = 1'b1; we1 = 1'b0; a1 = 10'h006;
    tick(x0, x1);
    chk("tie_after_reset", {31'b0, g0[0] | x0}, 32'h1);
    v0 = 1'b0;
    tick(x0, x1);
    idle(8);

    for (int q = 0; q < 4; q++) chk($sformatf("rd_queue_empty_%0d", q), rq[q].size(), 0);
    for (int i = 0; i < 2; i++) chk($sformatf("pb_queue_empty_%0d", i), pq[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
